// File: rtl/ov5640_cap_pkg.sv
// Shared types and constants for the OV5640 capture path and its display-side reader.
// The word layout lives here so writer and reader agree on where pixel n sits in a 64-bit word.
package ov5640_cap_pkg;

  typedef enum logic [1:0] {
    SKIP,
    WAIT_FRAME,
    CAPTURE
  } cap_state_e;

  localparam int DEF_IMG_WIDTH    = 1280;
  localparam int DEF_IMG_HEIGHT   = 720;
  localparam int DEF_BURST_PIXELS = 160;
  localparam int DEF_SKIP_FRAMES  = 10;

  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = 16;

  // Element 3 is bits [63:48]; pixel 0 of a word lands there.
  typedef logic [PIX_PER_WORD-1:0][PIX_W-1:0] cam_word_t;

  function automatic logic [1:0] pix_slot(input logic [1:0] n);
    return 2'(PIX_PER_WORD - 1) - n;
  endfunction

endpackage

// File: rtl/ov5640_capture_rgb565_packer.sv
// Pairs DVP bytes into RGB565 pixels (high byte first) and packs four pixels per 64-bit word.
// clear_i drops any partial byte, pixel or word; word_valid_o is a registered one-cycle strobe.
module rgb565_packer
  import ov5640_cap_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic        pack_en_i,
  input  logic [7:0]  data_i,
  output logic        pixel_done_o,
  output logic        word_valid_o,
  output logic [63:0] word_o
);

  logic       phase_q;
  logic [7:0] hi_q;
  logic [1:0] pix_idx_q;
  cam_word_t  acc_q, acc_d;
  cam_word_t  word_q;
  logic       word_valid_q;
  logic       pack;

  always_comb begin
    pixel_done_o = byte_valid_i & phase_q & ~clear_i;
    pack         = pixel_done_o & pack_en_i;
    acc_d        = acc_q;
    acc_d[pix_slot(pix_idx_q)] = {hi_q, data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q      <= 1'b0;
      hi_q         <= '0;
      pix_idx_q    <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear_i) begin
        phase_q   <= 1'b0;
        pix_idx_q <= '0;
      end else if (byte_valid_i) begin
        phase_q <= ~phase_q;
        if (!phase_q) hi_q <= data_i;
        if (pack) begin
          acc_q <= acc_d;
          if (pix_idx_q == 2'(PIX_PER_WORD - 1)) begin
            word_q       <= acc_d;
            word_valid_q <= 1'b1;
            pix_idx_q    <= '0;
          end else begin
            pix_idx_q <= pix_idx_q + 2'd1;
          end
        end
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: frame-skip FSM, line/pixel bookkeeping and DDR3 write/burst signalling.
// All inputs are registered once; edges compare the registered copy with its previous value.
module ov5640_capture
  import ov5640_cap_pkg::*;
#(
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int BURST_PIXELS = DEF_BURST_PIXELS,
  parameter int SKIP_FRAMES  = DEF_SKIP_FRAMES
) (
  input  logic        cmos_clk_i,
  input  logic        cmos_rst_i,
  input  logic        cmos_vsync_i,
  input  logic        cmos_href_i,
  input  logic [7:0]  cmos_data_i,
  output logic        ddr3_wr_addr_rst_o,
  output logic        ddr3_wr_en_o,
  output logic [63:0] ddr3_data_cam_o,
  output logic        ddr3_wr_req_o,
  output logic        frame_done_o,
  output logic        line_err_o
);

  localparam int WORDS_PER_BURST = BURST_PIXELS / PIX_PER_WORD;
  localparam int WCNT_W = (WORDS_PER_BURST > 1) ? $clog2(WORDS_PER_BURST) : 1;
  localparam int PCNT_W = $clog2(IMG_WIDTH + 2);
  localparam int LCNT_W = $clog2(IMG_HEIGHT + 1);
  localparam int SCNT_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_BURST - 1);
  localparam logic [PCNT_W-1:0] PCNT_FULL = PCNT_W'(IMG_WIDTH);
  localparam logic [PCNT_W-1:0] PCNT_SAT  = PCNT_W'(IMG_WIDTH + 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(IMG_HEIGHT - 1);
  localparam logic [LCNT_W-1:0] LCNT_END  = LCNT_W'(IMG_HEIGHT);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SKIP_FRAMES - 1);
  localparam cap_state_e RST_STATE = (SKIP_FRAMES == 0) ? WAIT_FRAME : SKIP;

  cap_state_e state_q, state_d;
  logic vsync_q, vsync_qq, href_q, href_qq;
  logic [7:0] data_q;
  logic vsync_rise, href_rise, href_fall;
  logic capture, frame_start, byte_valid, pack_en, line_end, packer_clear;
  logic pixel_done, word_valid;
  logic [63:0] word;
  logic in_line_q, in_line_d;
  logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [SCNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic line_err_q, line_err_d, done_q, done_d, req_q, req_d, arst_q;

  always_ff @(posedge cmos_clk_i or posedge cmos_rst_i) begin
    if (cmos_rst_i) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      data_q   <= '0;
    end else begin
      vsync_q  <= cmos_vsync_i;
      vsync_qq <= vsync_q;
      href_q   <= cmos_href_i;
      href_qq  <= href_q;
      data_q   <= cmos_data_i;
    end
  end

  assign vsync_rise = vsync_q & ~vsync_qq;
  assign href_rise  = href_q & ~href_qq;
  assign href_fall  = ~href_q & href_qq;

  always_ff @(posedge cmos_clk_i or posedge cmos_rst_i) begin
    if (cmos_rst_i) state_q <= RST_STATE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SKIP:       if (vsync_rise && skip_cnt_q == SCNT_LAST) state_d = WAIT_FRAME;
      WAIT_FRAME: if (vsync_rise) state_d = CAPTURE;
      CAPTURE:    state_d = CAPTURE;
      default:    state_d = RST_STATE;
    endcase
  end

  always_comb begin
    capture     = (state_q == CAPTURE);
    frame_start = vsync_rise & (state_q != SKIP);
  end

  // vsync wins over href: a coinciding byte is dropped and the line is never counted.
  assign byte_valid   = capture & href_q & ~vsync_rise & (in_line_q | href_rise);
  assign line_end     = capture & href_fall & in_line_q & ~vsync_rise;
  assign packer_clear = ~capture | ~href_q | vsync_rise;
  assign pack_en      = (line_cnt_q != LCNT_END) & (pix_cnt_q < PCNT_FULL);

  rgb565_packer u_packer (
    .clk_i        (cmos_clk_i),
    .rst_i        (cmos_rst_i),
    .clear_i      (packer_clear),
    .byte_valid_i (byte_valid),
    .pack_en_i    (pack_en),
    .data_i       (data_q),
    .pixel_done_o (pixel_done),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    in_line_d  = in_line_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    word_cnt_d = word_cnt_q;
    skip_cnt_d = skip_cnt_q;
    line_err_d = line_err_q;
    done_d     = 1'b0;
    req_d      = 1'b0;
    if (state_q == SKIP && vsync_rise) skip_cnt_d = skip_cnt_q + SCNT_W'(1);
    if (frame_start) begin
      in_line_d  = 1'b0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      word_cnt_d = '0;
      line_err_d = 1'b0;
    end else if (capture) begin
      if (href_rise) in_line_d = 1'b1;
      if (pixel_done && pix_cnt_q != PCNT_SAT) pix_cnt_d = pix_cnt_q + PCNT_W'(1);
      if (line_end) begin
        in_line_d = 1'b0;
        pix_cnt_d = '0;
        if (line_cnt_q != LCNT_END) line_cnt_d = line_cnt_q + LCNT_W'(1);
        if (line_cnt_q == LCNT_LAST) done_d = 1'b1;
        if (pix_cnt_q != PCNT_FULL) line_err_d = 1'b1;
      end
      if (word_valid) begin
        if (word_cnt_q == WCNT_LAST) begin
          word_cnt_d = '0;
          req_d      = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q + WCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge cmos_clk_i or posedge cmos_rst_i) begin
    if (cmos_rst_i) begin
      in_line_q  <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      word_cnt_q <= '0;
      skip_cnt_q <= '0;
      line_err_q <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      arst_q     <= 1'b0;
    end else begin
      in_line_q  <= in_line_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      word_cnt_q <= word_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      line_err_q <= line_err_d;
      done_q     <= done_d;
      req_q      <= req_d;
      arst_q     <= frame_start;
    end
  end

  assign ddr3_wr_addr_rst_o = arst_q;
  assign ddr3_wr_en_o       = word_valid;
  assign ddr3_data_cam_o    = word;
  assign ddr3_wr_req_o      = req_q;
  assign frame_done_o       = done_q;
  assign line_err_o         = line_err_q;

endmodule
